cmutex_merge_arb: RTL and testbench
===================================

# cmutex_merge_arb

Synchronous round-robin arbiter that shares one drive/free output channel between NUM_REQ drive/free requesters. It is the clocked front end for the mutex merge. Each requester's data is captured at its drive, so the payload stays stable until the downstream free. The block guarantees one outstanding transaction at a time on the shared channel, which keeps the downstream mutex merge conflict-free.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- DATA_WIDTH, 128, payload width per requester
- TIMEOUT_CYC, 1024, cycles in BUSY without i_freeNext before forced release; 0 disables the timeout

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- i_drive  in  NUM_REQ  per-requester drive pulse (one cycle)
- o_free  out  NUM_REQ  per-requester free pulse (one cycle)
- i_data  in  NUM_REQ*DATA_WIDTH  flat payloads; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
- o_driveNext  out  1  shared-channel drive pulse (one cycle)
- i_freeNext  in  1  shared-channel free pulse (one cycle)
- o_data  out  DATA_WIDTH  granted payload
- o_grant  out  NUM_REQ  one-hot grant, held through BUSY
- o_err  out  1  one-cycle protocol-violation pulse
- o_timeout  out  1  sticky timeout flag, cleared only by reset

## Operation
- Per requester k:
  - pend[k] is a pending flag and dreg[k] is a data register.
  - On i_drive[k] with pend[k]=0: set pend[k] and capture i_data slice into dreg[k].
  - On i_drive[k] with pend[k]=1: no capture, no change; o_err pulses.
- Round-robin pointer ptr (0..NUM_REQ-1):
  - The pick is the first set pend at or after ptr, wrapping modulo NUM_REQ.
  - After release of grant g, ptr = (g+1) mod NUM_REQ.
- States:
  - IDLE: if any pend is set (using registered pend only), latch grant g, load o_data from dreg[g], and go to DRIVE.
  - DRIVE: o_driveNext=1 for this one cycle; go to BUSY. If i_freeNext=1 in this cycle, go straight to RELEASE.
  - BUSY: wait for i_freeNext, which moves to RELEASE. Timeout counter cnt increments each cycle. If TIMEOUT_CYC≠0 and cnt reaches TIMEOUT_CYC-1, set o_timeout and go to RELEASE.
  - RELEASE: o_free[g]=1 for one cycle, clear pend[g], advance ptr, clear cnt; go to IDLE.
- Stray i_freeNext in IDLE or RELEASE: ignored, o_err pulses.
- i_drive[g] in the same cycle as o_free[g] is legal: pend[g] re-arms on that edge (clear then set, set wins).
- o_data and o_grant are held constant from DRIVE through RELEASE inclusive. Both are zero in IDLE.
- Reset (rst=0 at a clock edge), including mid-transaction:
  - clears pend, dreg, ptr, cnt, o_timeout; state to IDLE.
  - All outputs are 0 on the cycle after the edge.
  - No o_free is issued for an aborted transaction.

## Timing
- Reset values: o_free=0, o_driveNext=0, o_data=0, o_grant=0, o_err=0, o_timeout=0.
- i_drive[k] at cycle t, with the block idle: pend visible at t+1, IDLE picks at t+1, o_driveNext at t+2. Latency is 2 cycles.
- i_freeNext at cycle t in BUSY: RELEASE and o_free[g] at t+1. Next o_driveNext no earlier than t+3.
- i_freeNext in the DRIVE cycle: o_free[g] at the following cycle.
- Minimum transaction period on the shared channel: 3 cycles (DRIVE, RELEASE, IDLE).
- Simultaneous drives from several requesters: all latched in the same cycle, then served in round-robin order from ptr.
- All outputs are registered; there is no combinational path from any input to any output.

## Structure
- Package cmutex_arb_pkg holds:
  - state enum {IDLE, DRIVE, BUSY, RELEASE}
  - width function clog2 for the ptr and cnt widths
- Sub-module rr_pick: combinational, takes pend[NUM_REQ] and ptr, produces one-hot pick plus a valid flag. It is reused by later N-way merges.
- Top level holds pend/dreg storage, the FSM, the timeout counter and the output registers.

## Test plan
- Single requester: reset, then i_drive[2] at cycle 10 with i_data slice 2 = 0xA5 → o_driveNext at cycle 12, o_grant=0100, o_data=0xA5. i_freeNext at cycle 15 → o_free[2] at cycle 16, o_data=0 at cycle 17.
- Contention: i_drive=1111 at the same cycle with ptr=0, free returned 2 cycles after each drive → grants in order 0,1,2,3. Repeat with ptr=2 → order 2,3,0,1.
- Protocol errors: second i_drive[1] while pend[1]=1 → o_err one cycle, dreg[1] unchanged. i_freeNext in IDLE → o_err, no o_free.
- Timeout: TIMEOUT_CYC=8, no i_freeNext → o_timeout and o_free[g] 9 cycles after o_driveNext; o_timeout stays high until reset.
- Immediate free: i_freeNext in the o_driveNext cycle → o_free[g] next cycle, back to IDLE. Re-drive of the same port during o_free → next o_driveNext 2 cycles after o_free.
- Mid-operation reset: rst=0 while in BUSY → all outputs 0 next cycle, no o_free. Later i_freeNext → o_err only.

Source files
------------

// File: rtl/cmutex_arb_pkg.sv
// rtl/cmutex_arb_pkg.sv - shared types and helpers for the cmutex merge arbiter
//
// Purpose: FSM state encoding and a constant clog2 used to size the
// round-robin pointer and the timeout counter.
// Ports: none (package).

package cmutex_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    BUSY    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  // Smallest r with 2**r >= value; 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cmutex_merge_arb_rr_pick.sv
// rtl/cmutex_merge_arb_rr_pick.sv - combinational round-robin picker
//
// Purpose: selects the first set pending flag at or after ptr, wrapping
// modulo NUM_REQ.
// Ports:
//   pend  - per-requester pending flags
//   ptr   - round-robin start position (0..NUM_REQ-1)
//   pick  - one-hot selection, zero when nothing is pending
//   valid - at least one flag is pending

module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] pend,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic               valid
);

  // One extra bit so ptr + offset can exceed NUM_REQ-1 before the wrap.
  logic [PTR_W:0] idx;

  always_comb begin
    pick  = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, ptr} + (PTR_W + 1)'(i);
      if (idx >= (PTR_W + 1)'(NUM_REQ)) idx = idx - (PTR_W + 1)'(NUM_REQ);
      if (!valid && pend[idx[PTR_W-1:0]]) begin
        pick[idx[PTR_W-1:0]] = 1'b1;
        valid                = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cmutex_merge_arb.sv
// rtl/cmutex_merge_arb.sv - round-robin arbiter onto one drive/free channel
//
// Purpose: captures each requester's payload at its drive pulse, grants the
// shared channel to one requester at a time in round-robin order, and
// returns a free pulse to that requester when the channel frees (or times out).
// Ports:
//   clk, rst     - clock, synchronous active-low reset
//   i_drive      - per-requester drive pulses
//   o_free       - per-requester free pulses
//   i_data       - flat payloads, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//   o_driveNext  - shared-channel drive pulse
//   i_freeNext   - shared-channel free pulse
//   o_data       - granted payload, zero when idle
//   o_grant      - one-hot grant, zero when idle
//   o_err        - protocol violation pulse
//   o_timeout    - sticky timeout flag

module cmutex_merge_arb
  import cmutex_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 128,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            i_drive,
  output logic [NUM_REQ-1:0]            o_free,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
  output logic                          o_driveNext,
  input  logic                          i_freeNext,
  output logic [DATA_WIDTH-1:0]         o_data,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic                          o_err,
  output logic                          o_timeout
);

  localparam int PTR_W = clog2(NUM_REQ);
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  state_t                state;
  logic [NUM_REQ-1:0]    pend;
  logic [NUM_REQ-1:0]    pend_nxt;
  logic [NUM_REQ-1:0]    cap;
  logic [DATA_WIDTH-1:0] dreg [NUM_REQ];
  logic [PTR_W-1:0]      ptr;
  logic [PTR_W-1:0]      gidx;
  logic [PTR_W-1:0]      pick_idx;
  logic [CNT_W-1:0]      cnt;
  logic [NUM_REQ-1:0]    pick;
  logic                  pick_valid;
  logic                  drv_err;
  logic                  stray_free;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .pend  (pend),
    .ptr   (ptr),
    .pick  (pick),
    .valid (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick[k]) pick_idx = PTR_W'(k);
    end
  end

  // The granted flag is cleared first during RELEASE so a drive from the same
  // requester in that cycle is accepted and re-arms it.
  always_comb begin
    pend_nxt = pend;
    cap      = '0;
    drv_err  = 1'b0;
    if (state == RELEASE) pend_nxt[gidx] = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (i_drive[k]) begin
        if (!pend_nxt[k]) begin
          pend_nxt[k] = 1'b1;
          cap[k]      = 1'b1;
        end else begin
          drv_err = 1'b1;
        end
      end
    end
  end

  assign stray_free = i_freeNext && ((state == IDLE) || (state == RELEASE));

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NUM_REQ; k++) dreg[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (cap[k]) dreg[k] <= i_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      pend        <= '0;
      ptr         <= '0;
      gidx        <= '0;
      cnt         <= '0;
      o_free      <= '0;
      o_driveNext <= 1'b0;
      o_data      <= '0;
      o_grant     <= '0;
      o_err       <= 1'b0;
      o_timeout   <= 1'b0;
    end else begin
      pend        <= pend_nxt;
      o_driveNext <= 1'b0;
      o_free      <= '0;
      o_err       <= drv_err | stray_free;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state       <= DRIVE;
            o_driveNext <= 1'b1;
            o_grant     <= pick;
            gidx        <= pick_idx;
            o_data      <= dreg[pick_idx];
          end
        end
        DRIVE: begin
          if (i_freeNext) begin
            state  <= RELEASE;
            o_free <= o_grant;
          end else begin
            state <= BUSY;
          end
        end
        BUSY: begin
          if (i_freeNext) begin
            state  <= RELEASE;
            o_free <= o_grant;
          end else if ((TIMEOUT_CYC != 0) && (cnt == CNT_LAST)) begin
            state     <= RELEASE;
            o_free    <= o_grant;
            o_timeout <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: begin
          state   <= IDLE;
          cnt     <= '0;
          ptr     <= (gidx == PTR_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
          o_grant <= '0;
          o_data  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmutex_merge_arb.sv
// tb/tb_cmutex_merge_arb.sv - self-checking bench for cmutex_merge_arb

module tb_cmutex_merge_arb;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    i_drive = '0;
  logic [N*DW-1:0] i_data = '0;
  logic            i_freeNext = 1'b0;
  logic [N-1:0]    o_free;
  logic [N-1:0]    o_grant;
  logic            o_driveNext;
  logic            o_err;
  logic            o_timeout;
  logic [DW-1:0]   o_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cmutex_merge_arb #(
    .NUM_REQ     (N),
    .DATA_WIDTH  (DW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_drive     (i_drive),
    .o_free      (o_free),
    .i_data      (i_data),
    .o_driveNext (o_driveNext),
    .i_freeNext  (i_freeNext),
    .o_data      (o_data),
    .o_grant     (o_grant),
    .o_err       (o_err),
    .o_timeout   (o_timeout)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: requester table plus a description of where the channel
  // is in its transaction (0 waiting, 1 drive cycle, 2 busy, 3 release).
  bit            m_pend [N];
  logic [DW-1:0] m_dreg [N];
  int            m_ptr, m_g, m_stage, m_busy;
  bit            m_to;
  logic          e_drv, e_err, e_to;
  logic [N-1:0]  e_free, e_grant;
  logic [DW-1:0] e_data;

  function automatic void model_step();
    int  nstage;
    int  k;
    bit  err;
    if (!rst) begin
      for (int j = 0; j < N; j++) begin
        m_pend[j] = 0;
        m_dreg[j] = '0;
      end
      m_ptr = 0; m_g = 0; m_stage = 0; m_busy = 0; m_to = 0;
      e_drv = 0; e_err = 0; e_to = 0; e_free = '0; e_grant = '0; e_data = '0;
      return;
    end
    err    = 0;
    e_drv  = 0;
    e_free = '0;
    nstage = m_stage;
    case (m_stage)
      0: begin
        if (i_freeNext) err = 1;
        for (int i = 0; i < N; i++) begin
          k = (m_ptr + i) % N;
          if (nstage == 0 && m_pend[k]) begin
            nstage = 1;
            m_g    = k;
          end
        end
        if (nstage == 1) begin
          e_drv         = 1;
          e_grant       = '0;
          e_grant[m_g]  = 1'b1;
          e_data        = m_dreg[m_g];
        end
      end
      1: begin
        if (i_freeNext) nstage = 3;
        else begin
          nstage = 2;
          m_busy = 0;
        end
      end
      2: begin
        if (i_freeNext) nstage = 3;
        else if (TO != 0 && m_busy == TO - 1) begin
          nstage = 3;
          m_to   = 1;
        end else m_busy++;
      end
      default: begin
        if (i_freeNext) err = 1;
        m_pend[m_g] = 0;
        m_ptr       = (m_g + 1) % N;
        nstage      = 0;
        e_grant     = '0;
        e_data      = '0;
      end
    endcase
    if (nstage == 3 && m_stage != 3) e_free[m_g] = 1'b1;
    for (int j = 0; j < N; j++) begin
      if (i_drive[j]) begin
        if (!m_pend[j]) begin
          m_pend[j] = 1;
          m_dreg[j] = i_data[j*DW +: DW];
        end else err = 1;
      end
    end
    e_err   = err;
    e_to    = m_to;
    m_stage = nstage;
  endfunction

  // Applies inputs for one cycle just after a falling edge, then checks the
  // outputs at the next falling edge against the model.
  task automatic tick(input logic [N-1:0] drv, input logic [N*DW-1:0] dat,
                      input logic fr, input logic rs);
    i_drive    = drv;
    i_data     = dat;
    i_freeNext = fr;
    rst        = rs;
    model_step();
    @(negedge clk);
    check_eq("m_drive", o_driveNext, e_drv);
    check_eq("m_free", o_free, e_free);
    check_eq("m_data", o_data, e_data);
    check_eq("m_grant", o_grant, e_grant);
    check_eq("m_err", o_err, e_err);
    check_eq("m_timeout", o_timeout, e_to);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick('0, '0, 1'b0, 1'b1);
  endtask

  function automatic logic [N*DW-1:0] slot(input int k, input logic [DW-1:0] v);
    logic [N*DW-1:0] r;
    r = '0;
    r[k*DW +: DW] = v;
    return r;
  endfunction

  function automatic int grant_index(input logic [N-1:0] g);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (g[i]) r = i;
    return r;
  endfunction

  task automatic wait_drive(output int gi);
    int n;
    n = 0;
    while (o_driveNext !== 1'b1 && n < 20) begin
      tick('0, '0, 1'b0, 1'b1);
      n++;
    end
    check_eq("drive_seen", o_driveNext, 1);
    gi = grant_index(o_grant);
  endtask

  // All four requesters drive together; each grant is freed two cycles after
  // its drive pulse.
  task automatic round(input int e0, input int e1, input int e2, input int e3);
    int g;
    int exp_order [4];
    exp_order = '{e0, e1, e2, e3};
    tick(4'hF, {$urandom(), $urandom()}, 1'b0, 1'b1);
    for (int j = 0; j < 4; j++) begin
      wait_drive(g);
      check_eq("rr_order", g, exp_order[j]);
      idle(2);
      tick('0, '0, 1'b1, 1'b1);
    end
    idle(2);
  endtask

  initial begin
    int g;
    @(negedge clk);
    tick('0, '0, 1'b0, 1'b0);
    tick('0, '0, 1'b0, 1'b0);
    check_eq("rst_drive", o_driveNext, 0);
    check_eq("rst_free", o_free, 0);
    check_eq("rst_data", o_data, 0);
    check_eq("rst_grant", o_grant, 0);
    check_eq("rst_err", o_err, 0);
    check_eq("rst_timeout", o_timeout, 0);
    idle(3);

    // Single requester, two-cycle latency.
    tick(4'b0100, slot(2, 16'h00A5), 1'b0, 1'b1);
    check_eq("single_early", o_driveNext, 0);
    tick('0, '0, 1'b0, 1'b1);
    check_eq("single_drive", o_driveNext, 1);
    check_eq("single_grant", o_grant, 4'b0100);
    check_eq("single_data", o_data, 16'h00A5);
    idle(3);
    tick('0, '0, 1'b1, 1'b1);
    check_eq("single_free", o_free, 4'b0100);
    check_eq("single_hold", o_data, 16'h00A5);
    tick('0, '0, 1'b0, 1'b1);
    check_eq("single_data_clr", o_data, 0);
    check_eq("single_grant_clr", o_grant, 0);

    // Contention from ptr=0, then from ptr=2.
    tick('0, '0, 1'b0, 1'b0);
    idle(2);
    round(0, 1, 2, 3);
    tick(4'b0010, slot(1, 16'h0101), 1'b0, 1'b1);
    wait_drive(g);
    tick('0, '0, 1'b1, 1'b1);
    idle(2);
    round(2, 3, 0, 1);

    // Protocol errors.
    tick(4'b0010, slot(1, 16'h1111), 1'b0, 1'b1);
    check_eq("perr_none", o_err, 0);
    tick(4'b0010, slot(1, 16'h2222), 1'b0, 1'b1);
    check_eq("perr_err", o_err, 1);
    check_eq("perr_data_kept", o_data, 16'h1111);
    tick('0, '0, 1'b1, 1'b1);
    check_eq("perr_imm_free", o_free, 4'b0010);
    idle(2);
    tick('0, '0, 1'b1, 1'b1);
    check_eq("stray_err", o_err, 1);
    check_eq("stray_no_free", o_free, 0);

    // Timeout after TO busy cycles.
    tick(4'b0001, slot(0, 16'hBEEF), 1'b0, 1'b1);
    wait_drive(g);
    idle(8);
    check_eq("to_not_yet", o_free, 0);
    check_eq("to_flag_low", o_timeout, 0);
    idle(1);
    check_eq("to_free", o_free, 4'b0001);
    check_eq("to_flag", o_timeout, 1);
    idle(5);
    check_eq("to_sticky", o_timeout, 1);

    // Immediate free and re-drive during o_free.
    tick(4'b1000, slot(3, 16'h3C3C), 1'b0, 1'b1);
    wait_drive(g);
    tick('0, '0, 1'b1, 1'b1);
    check_eq("imm_free", o_free, 4'b1000);
    tick(4'b1000, slot(3, 16'h7777), 1'b0, 1'b1);
    check_eq("redrive_no_err", o_err, 0);
    check_eq("redrive_gap", o_driveNext, 0);
    tick('0, '0, 1'b0, 1'b1);
    check_eq("redrive_drive", o_driveNext, 1);
    check_eq("redrive_data", o_data, 16'h7777);
    tick('0, '0, 1'b1, 1'b1);
    idle(2);

    // Reset while busy.
    tick(4'b0100, slot(2, 16'h5A5A), 1'b0, 1'b1);
    wait_drive(g);
    idle(2);
    tick('0, '0, 1'b0, 1'b0);
    check_eq("mrst_grant", o_grant, 0);
    check_eq("mrst_data", o_data, 0);
    check_eq("mrst_timeout", o_timeout, 0);
    idle(3);
    check_eq("mrst_no_free", o_free, 0);
    tick('0, '0, 1'b1, 1'b1);
    check_eq("mrst_stray_err", o_err, 1);
    check_eq("mrst_stray_free", o_free, 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] drv;
      for (int j = 0; j < N; j++) drv[j] = ($urandom_range(0, 5) == 0);
      tick(drv, {$urandom(), $urandom()}, ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 199) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
